// File: rtl/instr_encoder.sv
// RV32I instruction encoder with a one-deep registered output stage.
// Each accepted request becomes one 32-bit word tagged with its byte address.
// Illegal requests still take an address slot, but they emit a NOP with out_err set.
// The output stage also keeps a saturating count of consumed words and a
// sticky error flag.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'hBFC0_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_class,
    input  logic [2:0]       in_alu_ctrl,
    input  logic             in_bne,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_addr,
    output logic             out_err,
    output logic [CNT_W-1:0] word_cnt,
    output logic             err_sticky
);

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_I    = 3'd1,
        CLS_LOAD = 3'd2,
        CLS_STOR = 3'd3,
        CLS_BR   = 3'd4,
        CLS_JAL  = 3'd5,
        CLS_JALR = 3'd6,
        CLS_RSVD = 3'd7
    } instr_class_e;

    localparam logic [6:0]  OP_R    = 7'b0110011;
    localparam logic [6:0]  OP_I    = 7'b0010011;
    localparam logic [6:0]  OP_LOAD = 7'b0000011;
    localparam logic [6:0]  OP_STOR = 7'b0100011;
    localparam logic [6:0]  OP_BR   = 7'b1100011;
    localparam logic [6:0]  OP_JAL  = 7'b1101111;
    localparam logic [6:0]  OP_JALR = 7'b1100111;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_instr_q, out_instr_d;
    logic [31:0]      out_addr_q, out_addr_d;
    logic             out_err_q, out_err_d;
    logic [31:0]      next_addr_q, next_addr_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             err_sticky_q, err_sticky_d;

    logic        accept;
    logic [31:0] enc_instr;
    logic        enc_err;
    logic [2:0]  alu_f3;
    logic        alu_ok;
    logic        imm12_ok;
    logic        imm13_ok;
    logic        imm21_ok;

    // A new word may enter when the output slot is empty or is being drained,
    // but never during a clear. Keeping in_valid out of this term avoids a
    // combinational loop through the producer.
    assign in_ready = !clear && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Signed range checks: the bits above the field must be a pure sign
    // extension. Branch and jal targets must also be halfword aligned.
    assign imm12_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
    assign imm13_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
    assign imm21_ok = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];

    // Translate the request into an RV32I word; any illegal combination
    // falls back to the canonical NOP with the error flag raised.
    always_comb begin
        enc_instr = NOP;
        enc_err   = 1'b0;
        alu_f3    = 3'b000;
        alu_ok    = 1'b1;

        case (in_alu_ctrl)
            3'b000:  alu_f3 = 3'b000;
            3'b001:  alu_f3 = 3'b000;
            3'b010:  alu_f3 = 3'b111;
            3'b011:  alu_f3 = 3'b110;
            3'b101:  alu_f3 = 3'b010;
            default: alu_ok = 1'b0;
        endcase

        case (instr_class_e'(in_class))
            CLS_R: begin
                if (alu_ok) begin
                    enc_instr = {(in_alu_ctrl == 3'b001) ? 7'b0100000 : 7'b0000000,
                                 in_rs2, in_rs1, alu_f3, in_rd, OP_R};
                end else begin
                    enc_err = 1'b1;
                end
            end
            CLS_I: begin
                if (alu_ok && (in_alu_ctrl != 3'b001) && imm12_ok) begin
                    enc_instr = {in_imm[11:0], in_rs1, alu_f3, in_rd, OP_I};
                end else begin
                    enc_err = 1'b1;
                end
            end
            CLS_LOAD: begin
                if (imm12_ok) begin
                    enc_instr = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD};
                end else begin
                    enc_err = 1'b1;
                end
            end
            CLS_STOR: begin
                if (imm12_ok) begin
                    enc_instr = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_STOR};
                end else begin
                    enc_err = 1'b1;
                end
            end
            CLS_BR: begin
                if (imm13_ok) begin
                    enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                                 {2'b00, in_bne}, in_imm[4:1], in_imm[11], OP_BR};
                end else begin
                    enc_err = 1'b1;
                end
            end
            CLS_JAL: begin
                if (imm21_ok) begin
                    enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                 in_rd, OP_JAL};
                end else begin
                    enc_err = 1'b1;
                end
            end
            CLS_JALR: begin
                if (imm12_ok) begin
                    enc_instr = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
                end else begin
                    enc_err = 1'b1;
                end
            end
            default: enc_err = 1'b1;
        endcase

        if (enc_err) begin
            enc_instr = NOP;
        end
    end

    // Next-state logic for the output slot, the address pointer, and the
    // statistics. Clear wins over everything else.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_addr_d   = out_addr_q;
        out_err_d    = out_err_q;
        next_addr_d  = next_addr_q;
        word_cnt_d   = word_cnt_q;
        err_sticky_d = err_sticky_q;

        if (clear) begin
            out_valid_d  = 1'b0;
            out_instr_d  = '0;
            out_addr_d   = BASE_ADDR;
            out_err_d    = 1'b0;
            next_addr_d  = BASE_ADDR;
            word_cnt_d   = '0;
            err_sticky_d = 1'b0;
        end else begin
            if (out_valid_q && out_ready && (word_cnt_q != '1)) begin
                word_cnt_d = word_cnt_q + CNT_W'(1);
            end
            if (accept) begin
                out_valid_d  = 1'b1;
                out_instr_d  = enc_instr;
                out_addr_d   = next_addr_q;
                out_err_d    = enc_err;
                next_addr_d  = next_addr_q + 32'd4;
                err_sticky_d = err_sticky_q || enc_err;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers. An asynchronous reset discards any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_addr_q   <= BASE_ADDR;
            out_err_q    <= 1'b0;
            next_addr_q  <= BASE_ADDR;
            word_cnt_q   <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_addr_q   <= out_addr_d;
            out_err_q    <= out_err_d;
            next_addr_q  <= next_addr_d;
            word_cnt_q   <= word_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_instr  = out_instr_q;
    assign out_addr   = out_addr_q;
    assign out_err    = out_err_q;
    assign word_cnt   = word_cnt_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder. It uses directed encodings, illegal requests,
// clear, backpressure and asynchronous-reset scenarios, and a randomized stream
// that is scored against an arithmetic RV32I reference model.
module tb_instr_encoder;

    localparam logic [31:0] BASE  = 32'hBFC0_0000;
    localparam int          CNT_W = 4;
    localparam int          CMAX  = (1 << CNT_W) - 1;
    localparam logic [31:0] NOPW  = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_class;
    logic [2:0]       in_alu_ctrl;
    logic             in_bne;
    logic [4:0]       in_rd, in_rs1, in_rs2;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [31:0]      out_addr;
    logic             out_err;
    logic [CNT_W-1:0] word_cnt;
    logic             err_sticky;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  cls;
        logic [2:0]  alu;
        logic        bne;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] instr;
    } vec_t;

    instr_encoder #(.BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_class   (in_class),
        .in_alu_ctrl(in_alu_ctrl),
        .in_bne     (in_bne),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .out_err    (out_err),
        .word_cnt   (word_cnt),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    // Reference encoder that works from the instruction-format rules with
    // integer arithmetic. It returns {illegal, word}.
    function automatic logic [32:0] ref_encode(input logic [2:0] cls, input logic [2:0] alu,
                                               input logic bne, input logic [4:0] rd,
                                               input logic [4:0] rs1, input logic [4:0] rs2,
                                               input logic [31:0] imm);
        int          s;
        bit          bad;
        logic [31:0] u, w, f3, r1, r2, d;
        s = imm; u = imm; bad = 0; w = 0; f3 = 0;
        r1 = 32'(rs1); r2 = 32'(rs2); d = 32'(rd);
        case (alu)
            3'd0, 3'd1: f3 = 0;
            3'd2:       f3 = 7;
            3'd3:       f3 = 6;
            3'd5:       f3 = 2;
            default:    f3 = 99;
        endcase
        case (cls)
            3'd0: begin
                bad = (f3 == 99);
                w = (((alu == 3'd1) ? 32'd32 : 32'd0) << 25) | (r2 << 20) | (r1 << 15)
                    | (f3 << 12) | (d << 7) | 32'h33;
            end
            3'd1: begin
                bad = (f3 == 99) || (alu == 3'd1) || s < -2048 || s > 2047;
                w = ((u & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | 32'h13;
            end
            3'd2: begin
                bad = s < -2048 || s > 2047;
                w = ((u & 32'hFFF) << 20) | (r1 << 15) | (32'd2 << 12) | (d << 7) | 32'h03;
            end
            3'd3: begin
                bad = s < -2048 || s > 2047;
                w = (((u >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (32'd2 << 12)
                    | ((u & 32'h1F) << 7) | 32'h23;
            end
            3'd4: begin
                bad = s < -4096 || s > 4094 || (u % 2) == 1;
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (r2 << 20)
                    | (r1 << 15) | (32'(bne) << 12) | (((u >> 1) & 32'hF) << 8)
                    | (((u >> 11) & 1) << 7) | 32'h63;
            end
            3'd5: begin
                bad = s < -1048576 || s > 1048574 || (u % 2) == 1;
                w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                    | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12)
                    | (d << 7) | 32'h6F;
            end
            3'd6: begin
                bad = s < -2048 || s > 2047;
                w = ((u & 32'hFFF) << 20) | (r1 << 15) | (d << 7) | 32'h67;
            end
            default: bad = 1;
        endcase
        if (bad) w = NOPW;
        return {bad, w};
    endfunction

    // Random immediates clustered around the legal range edges of every format.
    function automatic logic [31:0] gen_imm();
        int s;
        case ($urandom % 6)
            0:       s = int'($urandom % 32) - 16;
            1:       s = (($urandom % 2) != 0 ? 2040 : -2056) + int'($urandom % 16);
            2:       s = (($urandom % 2) != 0 ? 4088 : -4104) + int'($urandom % 16);
            3:       s = (($urandom % 2) != 0 ? 1048568 : -1048584) + int'($urandom % 16);
            4:       s = int'($urandom);
            default: s = int'($urandom % 4096) * 2 - 4096;
        endcase
        return s;
    endfunction

    task automatic set_req(input logic [2:0] cls, input logic [2:0] alu, input logic bne,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm);
        in_class = cls; in_alu_ctrl = alu; in_bne = bne;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    task automatic set_rand_req();
        set_req(3'($urandom), 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
                5'($urandom), gen_imm());
    endtask

    // Present one request for one clock while the consumer is ready.
    task automatic issue(input vec_t v);
        set_req(v.cls, v.alu, v.bne, v.rd, v.rs1, v.rs2, v.imm);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_req(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_err, out_instr, out_addr, word_cnt, err_sticky} !==
            {1'b0, 1'b0, 32'h0, BASE, CNT_W'(0), 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_state: got v=%b e=%b i=%h a=%h c=%0d s=%b, want v=0 e=0 i=0 a=%h c=0 s=0",
                     out_valid, out_err, out_instr, out_addr, word_cnt, err_sticky, BASE);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b, want 1", in_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_encoding();
        vec_t v[6];
        v[0] = '{3'd0, 3'd1, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,         32'h402081B3};
        v[1] = '{3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF00293};
        v[2] = '{3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020A423};
        v[3] = '{3'd4, 3'd0, 1'b1, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'hFE209CE3};
        v[4] = '{3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048,      32'h001000EF};
        v[5] = '{3'd6, 3'd0, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0,         32'h00008067};
        for (int k = 0; k < 6; k++) begin
            issue(v[k]);
            checks++;
            if ({out_valid, out_err, out_instr, out_addr} !==
                {1'b1, 1'b0, v[k].instr, BASE + 32'(4 * k)}) begin
                errors++;
                $display("[TB] FAIL encode_%0d: got v=%b e=%b i=%h a=%h, want v=1 e=0 i=%h a=%h",
                         k, out_valid, out_err, out_instr, out_addr, v[k].instr, BASE + 32'(4 * k));
            end
        end
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++;
            $display("[TB] FAIL encode_sticky: got %b, want 0", err_sticky);
        end
    endtask

    task automatic test_illegal();
        vec_t v[4];
        v[0] = '{3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3,    NOPW};
        v[1] = '{3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd2048, NOPW};
        v[2] = '{3'd7, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0,    NOPW};
        v[3] = '{3'd1, 3'd1, 1'b0, 5'd5, 5'd1, 5'd0, 32'd0,    NOPW};
        for (int k = 0; k < 4; k++) begin
            issue(v[k]);
            checks++;
            if ({out_valid, out_err, out_instr, out_addr} !==
                {1'b1, 1'b1, NOPW, BASE + 32'(4 * (6 + k))}) begin
                errors++;
                $display("[TB] FAIL illegal_%0d: got v=%b e=%b i=%h a=%h, want v=1 e=1 i=%h a=%h",
                         k, out_valid, out_err, out_instr, out_addr, NOPW, BASE + 32'(4 * (6 + k)));
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, err_sticky, word_cnt} !== {1'b0, 1'b1, CNT_W'(10)}) begin
            errors++;
            $display("[TB] FAIL illegal_drain: got v=%b s=%b c=%0d, want v=0 s=1 c=10",
                     out_valid, err_sticky, word_cnt);
        end
    endtask

    task automatic test_clear();
        issue('{3'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, NOPW});
        clear = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        set_req(0, 0, 0, 5'd9, 5'd1, 5'd2, 0);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_ready: got %b, want 0", in_ready);
        end
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        checks++;
        if ({out_valid, word_cnt, err_sticky} !== {1'b0, CNT_W'(0), 1'b0}) begin
            errors++;
            $display("[TB] FAIL clear_state: got v=%b c=%0d s=%b, want v=0 c=0 s=0",
                     out_valid, word_cnt, err_sticky);
        end
        issue('{3'd0, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 32'h0});
        checks++;
        if ({out_valid, out_err, out_instr, out_addr} !== {1'b1, 1'b0, 32'h000000B3, BASE}) begin
            errors++;
            $display("[TB] FAIL clear_next: got v=%b e=%b i=%h a=%h, want v=1 e=0 i=000000b3 a=%h",
                     out_valid, out_err, out_instr, out_addr, BASE);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [32:0] exp_w[7];
        vec_t        req[7];
        for (int k = 0; k < 7; k++) begin
            req[k] = '{3'($urandom), 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
                       5'($urandom), gen_imm(), 32'h0};
            exp_w[k] = ref_encode(req[k].cls, req[k].alu, req[k].bne, req[k].rd, req[k].rs1,
                                  req[k].rs2, req[k].imm);
        end
        set_req(req[0].cls, req[0].alu, req[0].bne, req[0].rd, req[0].rs1, req[0].rs2, req[0].imm);
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        set_req(req[1].cls, req[1].alu, req[1].bne, req[1].rd, req[1].rs1, req[1].rs2, req[1].imm);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({in_ready, out_valid, out_err, out_instr, out_addr} !==
                {1'b0, 1'b1, exp_w[0][32], exp_w[0][31:0], BASE + 32'd4}) begin
                errors++;
                $display("[TB] FAIL bp_hold_%0d: got r=%b v=%b e=%b i=%h a=%h, want r=0 v=1 e=%b i=%h a=%h",
                         c, in_ready, out_valid, out_err, out_instr, out_addr,
                         exp_w[0][32], exp_w[0][31:0], BASE + 32'd4);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int k = 1; k < 7; k++) begin
            set_req(req[k].cls, req[k].alu, req[k].bne, req[k].rd, req[k].rs1, req[k].rs2,
                    req[k].imm);
            @(posedge clk); #1;
            checks++;
            if ({out_valid, out_err, out_instr, out_addr} !==
                {1'b1, exp_w[k][32], exp_w[k][31:0], BASE + 32'(4 * (k + 1))}) begin
                errors++;
                $display("[TB] FAIL bp_stream_%0d: got v=%b e=%b i=%h a=%h, want v=1 e=%b i=%h a=%h",
                         k, out_valid, out_err, out_instr, out_addr, exp_w[k][32], exp_w[k][31:0],
                         BASE + 32'(4 * (k + 1)));
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, word_cnt} !== {1'b0, CNT_W'(8)}) begin
            errors++;
            $display("[TB] FAIL bp_count: got v=%b c=%0d, want v=0 c=8", out_valid, word_cnt);
        end
    endtask

    task automatic test_async_reset();
        set_req(3'd2, 0, 0, 5'd4, 5'd3, 0, 32'd16);
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_err, out_instr, out_addr, word_cnt, err_sticky} !==
            {1'b0, 1'b0, 32'h0, BASE, CNT_W'(0), 1'b0}) begin
            errors++;
            $display("[TB] FAIL async_reset: got v=%b e=%b i=%h a=%h c=%0d s=%b, want v=0 e=0 i=0 a=%h c=0 s=0",
                     out_valid, out_err, out_instr, out_addr, word_cnt, err_sticky, BASE);
        end
        set_req(3'd1, 3'd0, 0, 5'd7, 5'd0, 0, 32'd5);
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_err, out_instr, out_addr} !== {1'b1, 1'b0, 32'h00500393, BASE}) begin
            errors++;
            $display("[TB] FAIL async_first: got v=%b e=%b i=%h a=%h, want v=1 e=0 i=00500393 a=%h",
                     out_valid, out_err, out_instr, out_addr, BASE);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [64:0] exp_q[$];
        logic [32:0] r;
        logic [31:0] m_addr;
        int          m_cnt;
        bit          m_sticky;
        bit          exp_rdy;
        clear = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        m_addr = BASE; m_cnt = 0; m_sticky = 0;
        for (int c = 0; c < 600; c++) begin
            set_rand_req();
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            #1;
            exp_rdy = (exp_q.size() == 0) || out_ready;
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("[TB] FAIL rand_ready cycle %0d: got %b, want %b", c, in_ready, exp_rdy);
            end
            checks++;
            if (out_valid !== (exp_q.size() != 0)) begin
                errors++;
                $display("[TB] FAIL rand_valid cycle %0d: got %b, want %b", c, out_valid, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                checks++;
                if ({out_err, out_instr, out_addr} !== exp_q[0]) begin
                    errors++;
                    $display("[TB] FAIL rand_word cycle %0d: got e=%b i=%h a=%h, want e=%b i=%h a=%h",
                             c, out_err, out_instr, out_addr, exp_q[0][64], exp_q[0][63:32], exp_q[0][31:0]);
                end
            end
            checks++;
            if ({word_cnt, err_sticky} !== {CNT_W'(m_cnt), m_sticky}) begin
                errors++;
                $display("[TB] FAIL rand_stats cycle %0d: got c=%0d s=%b, want c=%0d s=%b",
                         c, word_cnt, err_sticky, m_cnt, m_sticky);
            end
            if (exp_q.size() != 0 && out_ready) begin
                void'(exp_q.pop_front());
                if (m_cnt < CMAX) m_cnt++;
            end
            if (in_valid && exp_rdy) begin
                r = ref_encode(in_class, in_alu_ctrl, in_bne, in_rd, in_rs1, in_rs2, in_imm);
                exp_q.push_back({r, m_addr});
                m_sticky = m_sticky | r[32];
                m_addr   = m_addr + 32'd4;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_encoding();
        test_illegal();
        test_clear();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'hBFC0_0000, byte address given to the first encoded word after reset or clear.
REQ-002 Parameter CNT_W, default 16, width of the saturating word counter.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 clear  in  1  synchronous restart of the address/counter/output stage.
REQ-006 in_valid  in  1  request to encode one instruction.
REQ-007 in_ready  out  1  encoder can accept a request this cycle.
REQ-008 in_class  in  3  0 R-ALU, 1 I-ALU, 2 load, 3 store, 4 branch, 5 jal, 6 jalr, 7 reserved.
REQ-009 in_alu_ctrl  in  3  000 add, 001 sub, 010 and, 011 or, 101 slt; other values are invalid.
REQ-010 in_bne  in  1  branch only: 0 beq, 1 bne.
REQ-011 in_rd, in_rs1, in_rs2  in  5 each  register indices.
REQ-012 in_imm  in  32  signed immediate/offset in two's complement.
REQ-013 out_valid  out  1  out_instr/out_addr/out_err hold a word.
REQ-014 out_ready  in  1  consumer accepts the word.
REQ-015 out_instr  out  32  encoded RV32I word.
REQ-016 out_addr  out  32  byte address of out_instr.
REQ-017 out_err  out  1  word was an illegal request and was replaced by a NOP.
REQ-018 word_cnt  out  CNT_W  count of words accepted by the consumer; saturates at all-ones.
REQ-019 err_sticky  out  1  set by any emitted word with out_err=1; cleared only by reset or clear.

Function
REQ-020 in_ready SHALL be !out_valid || out_ready, with no combinational path from in_valid.
REQ-021 Accept = in_valid && in_ready; the encoded word SHALL appear with out_valid=1 on the next cycle (latency 1). Back-to-back accepts run at one per cycle while out_ready=1.
REQ-022 While out_valid=1 && out_ready=0, out_* SHALL hold stable.
REQ-023 Accept and consumer handshake in the same cycle SHALL replace the output with the new word and keep out_valid=1.
REQ-024 out_addr SHALL be BASE_ADDR for the first word and increase by 4 per accepted input, wrapping modulo 2^32.
REQ-025 ALU funct3 mapping: add/sub 000, slt 010, or 110, and 111. R-type SHALL set funct7=0100000 for sub, else 0000000.
REQ-026 I-ALU: sub or an unmapped alu_ctrl SHALL be illegal. R-type: an unmapped alu_ctrl SHALL be illegal.
REQ-027 The formats SHALL be encoded as follows:
- R: opcode 0110011.
- I-ALU: opcode 0010011, imm[11:0].
- load: opcode 0000011, funct3 010.
- store: opcode 0100011, funct3 010, imm[11:5]/imm[4:0] split.
- branch: opcode 1100011, funct3 000/001, bits imm[12|10:5] and imm[4:1|11].
- jal: opcode 1101111, bits imm[20|10:1|11|19:12].
- jalr: opcode 1100111, funct3 000.
REQ-028 Immediate range: I/load/store/jalr SHALL use [-2048, 2047], branch [-4096, 4094], jal [-2^20, 2^20-2]. An out-of-range immediate SHALL be illegal.
REQ-029 A branch or jal immediate with imm[0]=1 SHALL be illegal. in_class=7 SHALL be illegal.
REQ-030 An illegal request SHALL still be accepted and consume an address. It SHALL emit out_instr=32'h0000_0013 with out_err=1.
REQ-031 word_cnt SHALL increment on each out_valid && out_ready and hold at its maximum value.
REQ-032 clear=1 SHALL have priority over accept. On the next edge it SHALL set out_valid=0, next address=BASE_ADDR, word_cnt=0 and err_sticky=0. in_ready SHALL be 0 during clear.

Reset
REQ-033 rst_n=0 SHALL immediately force out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, word_cnt=0, err_sticky=0 and next address=BASE_ADDR. A word in flight SHALL be discarded.
REQ-034 The block SHALL accept input on the first rising edge after rst_n deasserts.

Verification
REQ-035 Encoding check (out_ready=1):
- R sub x3,x1,x2 -> 32'h402081B3 @ BFC00000.
- addi x5,x0,-1 -> 32'hFFF00293 @ BFC00004.
REQ-036 Store/branch/jump encoding:
- sw x2,8(x1) -> 32'h0020A423.
- bne x1,x2,-8 -> 32'hFE209CE3.
- jal x1,2048 -> 32'h001000EF.
- jalr x0,0(x1) -> 32'h00008067.
REQ-037 Illegal requests (branch imm=3, addi imm=2048, class 7, I-ALU sub) -> each gives 32'h00000013 with out_err=1. Addresses still advance and err_sticky=1.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and out_* stable. Release -> one word per cycle, no loss or duplication, word_cnt matches.
REQ-039 Assert rst_n=0 mid-stream while out_valid=1 -> out_valid=0 asynchronously. The next word after release is at BFC00000.
REQ-040 clear together with in_valid=1 -> request dropped, out_valid=0 and word_cnt=0. The next word is at BFC00000.
